// File: rtl/jtframe_i8742_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module : jtframe_i8742_ctrl_pkg
// Brief  : State, status-bit and a0 encodings for the i8742 host sequencer.
// Rev    : 1.0
// ============================================================================
package jtframe_i8742_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    POLL  = 3'd1,
    CHECK = 3'd2,
    XFER  = 3'd3,
    DONE  = 3'd4,
    FAIL  = 3'd5
  } state_t;

  localparam int   OBF     = 0;
  localparam int   IBF     = 1;
  localparam logic A0_DATA = 1'b0;
  localparam logic A0_STAT = 1'b1;

endpackage
`default_nettype wire

// File: rtl/jtframe_i8742_ctrl_strb.sv
`default_nettype none
// ============================================================================
// Module : jtframe_i8742_ctrl_strb
// Brief  : cen-tick strobe timer; last is high on the final tick of a strobe.
// Rev    : 1.0
// ============================================================================
module jtframe_i8742_ctrl_strb #(
  parameter int STROBE = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic cen,
  input  logic load,
  output logic last
);

  localparam logic [3:0] C_RELOAD = 4'(STROBE - 1);

  logic [3:0] r_cnt;

  // Loaded on state entry, so the entry edge itself is never counted as a tick
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (load) begin
      r_cnt <= C_RELOAD;
    end else if (cen && r_cnt != 4'd0) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  assign last = cen && (r_cnt == 4'd0);

endmodule
`default_nettype wire

// File: rtl/jtframe_i8742_ctrl.sv
`default_nettype none
// ============================================================================
// Module : jtframe_i8742_ctrl
// Brief  : Host-side bus sequencer for the i8742 (UPI-41) host port.
//          Optional statistics port: define JTFRAME_I8742_CTRL_STATS_EN.
// Rev    : 1.0
// ============================================================================
module jtframe_i8742_ctrl
  import jtframe_i8742_ctrl_pkg::*;
#(
  parameter int STROBE = 3,
  parameter int TOUT   = 1023
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cen,
  input  logic       req,
  input  logic       we,
  input  logic       cmd,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       ack,
  output logic       tout,
  output logic       busy,
`ifdef JTFRAME_I8742_CTRL_STATS_EN
  input  logic [1:0] st_addr,
  output logic [7:0] st_dout,
`endif
  output logic       upi_a0,
  output logic       upi_cs_n,
  output logic       upi_rdn,
  output logic       upi_wrn,
  output logic [7:0] upi_dout,
  input  logic [7:0] upi_din
);

  localparam logic [16:0] C_TOUT = 17'(TOUT);

  state_t      r_state;
  state_t      w_nxt;
  logic        r_we;
  logic        r_cmd;
  logic [7:0]  r_wdata;
  logic [1:0]  r_flags;
  logic [15:0] r_polls;
  logic        w_last;
  logic        w_load;
  logic        w_ready;
  logic        w_give_up;
  logic        w_cs_n;
  logic        w_rdn;
  logic        w_wrn;
  logic        w_a0;
  logic [7:0]  w_dout;
  logic        w_ack;
  logic        w_tout;

  jtframe_i8742_ctrl_strb #(
    .STROBE (STROBE)
  ) u_strb (
    .clk   (clk),
    .rst_n (rst_n),
    .cen   (cen),
    .load  (w_load),
    .last  (w_last)
  );

  assign w_ready   = r_we ? !r_flags[IBF] : r_flags[OBF];
  assign w_give_up = ({1'b0, r_polls} + 17'd1) == C_TOUT;
  assign w_load    = (w_nxt != r_state) && (w_nxt == POLL || w_nxt == XFER);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_nxt;
  end

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      IDLE:  if (req) w_nxt = POLL;
      POLL:  if (w_last) w_nxt = CHECK;
      CHECK: if (cen) begin
               if (w_ready)        w_nxt = XFER;
               else if (w_give_up) w_nxt = FAIL;
               else                w_nxt = POLL;
             end
      XFER:  if (w_last) w_nxt = DONE;
      DONE:  if (cen) w_nxt = IDLE;
      FAIL:  if (cen) w_nxt = IDLE;
      default: w_nxt = IDLE;
    endcase
  end

  // Bus pins are decoded from the next state so they switch with the state register
  always_comb begin
    w_cs_n = 1'b1;
    w_rdn  = 1'b1;
    w_wrn  = 1'b1;
    w_a0   = A0_DATA;
    w_dout = 8'd0;
    w_ack  = (r_state == DONE) && (w_nxt == IDLE);
    w_tout = (r_state == FAIL) && (w_nxt == IDLE);
    case (w_nxt)
      POLL: begin
        w_cs_n = 1'b0;
        w_rdn  = 1'b0;
        w_a0   = A0_STAT;
      end
      XFER: begin
        w_cs_n = 1'b0;
        if (r_we) begin
          w_a0   = r_cmd;
          w_wrn  = 1'b0;
          w_dout = r_wdata;
        end else begin
          w_rdn  = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we    <= 1'b0;
      r_cmd   <= 1'b0;
      r_wdata <= 8'd0;
      r_flags <= 2'd0;
      r_polls <= 16'd0;
    end else begin
      if (r_state == IDLE && req) begin
        r_we    <= we;
        r_cmd   <= cmd;
        r_wdata <= wdata;
        r_polls <= 16'd0;
      end
      if (r_state == POLL && w_last) r_flags <= {upi_din[IBF], upi_din[OBF]};
      if (r_state == CHECK && cen && !w_ready) r_polls <= r_polls + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      upi_cs_n <= 1'b1;
      upi_rdn  <= 1'b1;
      upi_wrn  <= 1'b1;
      upi_a0   <= 1'b0;
      upi_dout <= 8'd0;
      rdata    <= 8'd0;
      ack      <= 1'b0;
      tout     <= 1'b0;
      busy     <= 1'b0;
    end else begin
      upi_cs_n <= w_cs_n;
      upi_rdn  <= w_rdn;
      upi_wrn  <= w_wrn;
      upi_a0   <= w_a0;
      upi_dout <= w_dout;
      ack      <= w_ack;
      tout     <= w_tout;
      busy     <= (w_nxt != IDLE);
      if (r_state == XFER && w_last && !r_we) rdata <= upi_din;
    end
  end

`ifdef JTFRAME_I8742_CTRL_STATS_EN
  logic [7:0] r_nxfer;
  logic [7:0] r_ntout;
  logic [7:0] r_last_st;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_nxfer   <= 8'd0;
      r_ntout   <= 8'd0;
      r_last_st <= 8'd0;
      st_dout   <= 8'd0;
    end else begin
      if (w_ack) r_nxfer <= r_nxfer + 8'd1;
      if (w_tout && r_ntout != 8'hFF) r_ntout <= r_ntout + 8'd1;
      if (r_state == POLL && w_last) r_last_st <= upi_din;
      case (st_addr)
        2'd0:    st_dout <= r_nxfer;
        2'd1:    st_dout <= r_ntout;
        2'd2:    st_dout <= r_last_st;
        default: st_dout <= {5'd0, r_state};
      endcase
    end
  end
`endif

endmodule
`default_nettype wire
